// File: rtl/data_mem_bx.sv
// data_mem_bx: byte-addressable MIPS32 data memory with sub-word loads/stores,
// alignment/range rejection, one-cycle registered reads and a saturating error counter.
module data_mem_bx #(
  parameter int DEPTH = 1024,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_i,
  input  logic                 we_i,
  input  logic [1:0]           size_i,
  input  logic                 uns_i,
  input  logic [31:0]          a_i,
  input  logic [31:0]          wd_i,
  output logic [31:0]          rd_o,
  output logic                 rvalid_o,
  output logic                 err_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o
);
  localparam int AW = $clog2(DEPTH);
  logic [31:0] mem [DEPTH];
  logic [AW-1:0] idx;
  logic [31:0] word, ld, wdat, rd_q, rd_d;
  logic [7:0] b;
  logic [15:0] h;
  logic [3:0] be;
  logic bad, ld_ok, st_ok, rvalid_q, err_q;
  logic [ERR_CNT_W-1:0] cnt_q, cnt_d;
  always_comb begin
    idx = a_i[AW+1:2];
    word = mem[idx];
    b = word[{a_i[1:0], 3'b000} +: 8];
    h = a_i[1] ? word[31:16] : word[15:0];
    bad = size_i == 2'b11 | (size_i == 2'b01 & a_i[0]) | (size_i == 2'b10 & |a_i[1:0]) | |a_i[31:AW+2];
    st_ok = req_i & we_i & ~bad;
    ld_ok = req_i & ~we_i & ~bad;
    ld = size_i == 2'b00 ? {{24{~uns_i & b[7]}}, b} :
         size_i == 2'b01 ? {{16{~uns_i & h[15]}}, h} : word;
    be = size_i == 2'b00 ? 4'b0001 << a_i[1:0] :
         size_i == 2'b01 ? (a_i[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    // store data is replicated so each enabled lane picks up the right bytes
    wdat = size_i == 2'b00 ? {4{wd_i[7:0]}} : size_i == 2'b01 ? {2{wd_i[15:0]}} : wd_i;
    rd_d = req_i & bad ? '0 : ld_ok ? ld : rd_q;
    cnt_d = req_i & bad & ~&cnt_q ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q <= '0;
      rvalid_q <= 1'b0;
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      rd_q <= rd_d;
      rvalid_q <= ld_ok;
      err_q <= req_i & bad;
      cnt_q <= cnt_d;
    end
  end
  // memory is never reset, but a store sampled while rst is high is dropped
  always_ff @(posedge clk) begin
    if (st_ok & ~rst)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][8*i +: 8] <= wdat[8*i +: 8];
  end
  assign rd_o = rd_q;
  assign rvalid_o = rvalid_q;
  assign err_o = err_q;
  assign err_cnt_o = cnt_q;
endmodule

// File: tb/tb_data_mem_bx.sv
// tb_data_mem_bx: directed vector table plus reset/saturation sequences for data_mem_bx.
module tb_data_mem_bx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req = 1'b0, we = 1'b0, uns = 1'b0;
  logic [1:0] size = 2'b10;
  logic [31:0] a = '0, wd = '0;
  logic [31:0] rd1, rd2;
  logic rv1, rv2, er1, er2;
  logic [7:0] cnt1;
  logic [1:0] cnt2;
  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  data_mem_bx #(.DEPTH(1024), .ERR_CNT_W(8)) dut1 (
    .clk(clk), .rst(rst), .req_i(req), .we_i(we), .size_i(size), .uns_i(uns),
    .a_i(a), .wd_i(wd), .rd_o(rd1), .rvalid_o(rv1), .err_o(er1), .err_cnt_o(cnt1));
  data_mem_bx #(.DEPTH(1024), .ERR_CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .req_i(req), .we_i(we), .size_i(size), .uns_i(uns),
    .a_i(a), .wd_i(wd), .rd_o(rd2), .rvalid_o(rv2), .err_o(er2), .err_cnt_o(cnt2));

  typedef struct {
    logic we;
    logic [1:0] sz;
    logic un;
    logic [31:0] a;
    logic [31:0] wd;
    logic rv;
    logic er;
    logic [31:0] rd;
    int cnt;
  } vec_t;
  vec_t v[$];

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic w, input logic [1:0] s, input logic u,
                       input logic [31:0] ad, input logic [31:0] d);
    @(negedge clk);
    req = r; we = w; size = s; uns = u; a = ad; wd = d;
  endtask

  initial begin
    // we, size, uns, addr, wdata, rvalid, err, rd, err_cnt
    v.push_back('{1'b1, 2'b10, 1'b0, 32'h0,    32'hCAFEF00D, 1'b0, 1'b0, 32'h0,        0});
    v.push_back('{1'b1, 2'b10, 1'b0, 32'h10,   32'h8899AABC, 1'b0, 1'b0, 32'h0,        0});
    v.push_back('{1'b0, 2'b10, 1'b0, 32'h10,   32'h0,        1'b1, 1'b0, 32'h8899AABC, 0});
    v.push_back('{1'b1, 2'b00, 1'b0, 32'h11,   32'hFFFFFF7F, 1'b0, 1'b0, 32'h8899AABC, 0});
    v.push_back('{1'b0, 2'b10, 1'b0, 32'h10,   32'h0,        1'b1, 1'b0, 32'h88997FBC, 0});
    v.push_back('{1'b0, 2'b00, 1'b0, 32'h13,   32'h0,        1'b1, 1'b0, 32'hFFFFFF88, 0});
    v.push_back('{1'b0, 2'b00, 1'b1, 32'h13,   32'h0,        1'b1, 1'b0, 32'h00000088, 0});
    v.push_back('{1'b0, 2'b00, 1'b0, 32'h11,   32'h0,        1'b1, 1'b0, 32'h0000007F, 0});
    v.push_back('{1'b0, 2'b00, 1'b1, 32'h12,   32'h0,        1'b1, 1'b0, 32'h00000099, 0});
    v.push_back('{1'b1, 2'b01, 1'b0, 32'h22,   32'hABCD1234, 1'b0, 1'b0, 32'h00000099, 0});
    v.push_back('{1'b0, 2'b01, 1'b1, 32'h22,   32'h0,        1'b1, 1'b0, 32'h00001234, 0});
    v.push_back('{1'b1, 2'b01, 1'b0, 32'h20,   32'h0000F00D, 1'b0, 1'b0, 32'h00001234, 0});
    v.push_back('{1'b0, 2'b01, 1'b0, 32'h20,   32'h0,        1'b1, 1'b0, 32'hFFFFF00D, 0});
    v.push_back('{1'b0, 2'b01, 1'b1, 32'h20,   32'h0,        1'b1, 1'b0, 32'h0000F00D, 0});
    v.push_back('{1'b0, 2'b01, 1'b0, 32'h22,   32'h0,        1'b1, 1'b0, 32'h00001234, 0});
    v.push_back('{1'b0, 2'b10, 1'b0, 32'h20,   32'h0,        1'b1, 1'b0, 32'h1234F00D, 0});
    v.push_back('{1'b0, 2'b10, 1'b1, 32'h10,   32'h0,        1'b1, 1'b0, 32'h88997FBC, 0});
    v.push_back('{1'b1, 2'b10, 1'b0, 32'hFFC,  32'h0BADBEEF, 1'b0, 1'b0, 32'h88997FBC, 0});
    v.push_back('{1'b0, 2'b10, 1'b0, 32'hFFC,  32'h0,        1'b1, 1'b0, 32'h0BADBEEF, 0});
    v.push_back('{1'b1, 2'b01, 1'b0, 32'h21,   32'h0000FFFF, 1'b0, 1'b1, 32'h0,        1});
    v.push_back('{1'b0, 2'b10, 1'b0, 32'h20,   32'h0,        1'b1, 1'b0, 32'h1234F00D, 1});
    v.push_back('{1'b1, 2'b10, 1'b0, 32'h22,   32'hDEADBEEF, 1'b0, 1'b1, 32'h0,        2});
    v.push_back('{1'b0, 2'b10, 1'b0, 32'h20,   32'h0,        1'b1, 1'b0, 32'h1234F00D, 2});
    v.push_back('{1'b0, 2'b11, 1'b0, 32'h20,   32'h0,        1'b0, 1'b1, 32'h0,        3});
    v.push_back('{1'b0, 2'b10, 1'b0, 32'h20,   32'h0,        1'b1, 1'b0, 32'h1234F00D, 3});
    v.push_back('{1'b1, 2'b10, 1'b0, 32'h1000, 32'h55555555, 1'b0, 1'b1, 32'h0,        4});
    v.push_back('{1'b0, 2'b10, 1'b0, 32'h0,    32'h0,        1'b1, 1'b0, 32'hCAFEF00D, 4});
    v.push_back('{1'b0, 2'b00, 1'b0, 32'h1003, 32'h0,        1'b0, 1'b1, 32'h0,        5});

    #1;
    chk("reset rd", rd1, 32'h0);
    chk("reset rvalid", {31'h0, rv1}, 32'h0);
    chk("reset err", {31'h0, er1}, 32'h0);
    chk("reset err_cnt", {24'h0, cnt1}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < v.size(); i++) begin
      drive(1'b1, v[i].we, v[i].sz, v[i].un, v[i].a, v[i].wd);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d rvalid", i), {31'h0, rv1}, {31'h0, v[i].rv});
      chk($sformatf("v%0d err", i), {31'h0, er1}, {31'h0, v[i].er});
      chk($sformatf("v%0d rd", i), rd1, v[i].rd);
      chk($sformatf("v%0d err_cnt", i), {24'h0, cnt1}, v[i].cnt);
      chk($sformatf("v%0d err_cnt2", i), {30'h0, cnt2}, v[i].cnt > 3 ? 3 : v[i].cnt);
    end

    drive(1'b0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    @(posedge clk);
    #1;
    chk("idle rvalid", {31'h0, rv1}, 32'h0);
    chk("idle err", {31'h0, er1}, 32'h0);
    chk("idle rd hold", rd1, 32'h0);

    // saturation: clean counters first
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 1'b0, 2'b11, 1'b0, 32'h0, 32'h0);
      @(posedge clk);
      #1;
      chk($sformatf("sat%0d err2", k), {31'h0, er2}, 32'h1);
      chk($sformatf("sat%0d cnt2", k), {30'h0, cnt2}, k < 2 ? k + 1 : 3);
      chk($sformatf("sat%0d cnt1", k), {24'h0, cnt1}, k + 1);
    end

    // reset during traffic
    drive(1'b1, 1'b1, 2'b10, 1'b0, 32'h40, 32'h11112222);
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
    @(posedge clk);
    #1;
    chk("pre-rst rvalid", {31'h0, rv1}, 32'h1);
    chk("pre-rst rd", rd1, 32'h11112222);
    #2;
    rst = 1'b1;
    #1;
    chk("async rst rd", rd1, 32'h0);
    chk("async rst rvalid", {31'h0, rv1}, 32'h0);
    chk("async rst err_cnt", {24'h0, cnt1}, 32'h0);
    chk("async rst err_cnt2", {30'h0, cnt2}, 32'h0);
    drive(1'b1, 1'b1, 2'b10, 1'b0, 32'h40, 32'h99999999);
    @(posedge clk);
    #1;
    chk("in-rst rvalid", {31'h0, rv1}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    req = 1'b1; we = 1'b0; size = 2'b10; a = 32'h40;
    @(posedge clk);
    #1;
    chk("post-rst rvalid", {31'h0, rv1}, 32'h1);
    chk("post-rst rd", rd1, 32'h11112222);
    chk("post-rst err", {31'h0, er1}, 32'h0);
    @(negedge clk);
    req = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
